// File: rtl/var_dly_line.sv
// var_dly_line: runtime-programmable sample delay line for one receive channel.
// Each accepted sample is written into a circular RAM and re-emitted exactly
// D accepted samples later. D is reloadable at run time. A fill counter makes
// sure stale RAM contents are never flagged valid after reset, load or flush.
module var_dly_line #(
  parameter int DW       = 12,
  parameter int DEPTH    = 64,
  parameter int DLY_INIT = 16,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] iData,
  input  logic          iValid,
  input  logic [AW:0]   iDly,
  input  logic          iDlyLd,
  input  logic          iFlush,
  output logic [DW-1:0] oData,
  output logic          oValid,
  output logic          oPrimed
);

  typedef enum logic {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  // Delay, fill count and write pointer (address stage, p0)
  logic [AW:0]   r_dly;
  logic [AW:0]   w_dly_nxt;
  logic [AW:0]   r_fcnt;
  logic [AW:0]   w_fcnt_nxt;
  logic [AW-1:0] r_wp_p0;
  logic [AW-1:0] w_rp_p0;
  logic          w_reload;
  logic          w_vld_p0;

  // Sample storage; deliberately not reset
  logic [DW-1:0] r_mem [DEPTH];

  // Registered output stage (p1)
  logic [DW-1:0] r_data_p1;
  logic          r_vld_p1;
  logic          r_primed_p1;

  // A delay of 0 is meaningless and anything above DEPTH cannot be stored,
  // so requests are forced into 1..DEPTH.
  function automatic logic [AW:0] clamp_dly(input logic [AW:0] dly);
    if (dly == '0) begin
      return (AW+1)'(1);
    end
    if (dly > (AW+1)'(DEPTH)) begin
      return (AW+1)'(DEPTH);
    end
    return dly;
  endfunction

  // Read address is D entries behind the write pointer. Only the low AW bits
  // of D take part, so D = DEPTH reads the slot about to be overwritten,
  // which the read-before-write RAM returns as the DEPTH-old sample.
  function automatic logic [AW-1:0] rd_addr(input logic [AW-1:0] wp,
                                            input logic [AW:0]   dly);
    return wp - dly[AW-1:0];
  endfunction

  assign w_rp_p0  = rd_addr(r_wp_p0, r_dly);
  assign w_reload = iDlyLd | iFlush;

  // A valid output needs an accepted sample, a fully primed buffer, and no
  // load/flush in the same cycle (which restarts the fill).
  assign w_vld_p0 = iValid & (r_state == S_RUN) & ~w_reload;

  // Next-state, next delay and next fill count
  always_comb begin
    w_dly_nxt   = iDlyLd ? clamp_dly(iDly) : r_dly;
    w_fcnt_nxt  = r_fcnt;
    w_state_nxt = r_state;
    if (w_reload) begin
      // A sample accepted together with the load/flush is the first of the
      // new fill; with D = 1 that alone primes the buffer.
      w_fcnt_nxt  = iValid ? (AW+1)'(1) : '0;
      w_state_nxt = (iValid && (w_dly_nxt == (AW+1)'(1))) ? S_RUN : S_FILL;
    end else begin
      case (r_state)
        S_FILL: begin
          if (iValid) begin
            w_fcnt_nxt = r_fcnt + (AW+1)'(1);
            if (w_fcnt_nxt == r_dly) begin
              w_state_nxt = S_RUN;
            end
          end
        end
        S_RUN: begin
          // Fill count stays saturated at D while running
          w_fcnt_nxt = r_fcnt;
        end
        default: begin
          w_state_nxt = S_FILL;
        end
      endcase
    end
  end

  // State register, delay, fill count and write pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FILL;
      r_dly   <= (AW+1)'(DLY_INIT);
      r_fcnt  <= '0;
      r_wp_p0 <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dly   <= w_dly_nxt;
      r_fcnt  <= w_fcnt_nxt;
      if (iValid) begin
        r_wp_p0 <= r_wp_p0 + AW'(1);
      end
    end
  end

  // Circular buffer write; every accepted sample is stored, even during fill
  always_ff @(posedge clk) begin
    if (iValid) begin
      r_mem[r_wp_p0] <= iData;
    end
  end

  // Output stage: RAM read (old content on same address), valid and primed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_p1   <= '0;
      r_vld_p1    <= 1'b0;
      r_primed_p1 <= 1'b0;
    end else begin
      if (iValid) begin
        r_data_p1 <= r_mem[w_rp_p0];
      end
      r_vld_p1    <= w_vld_p0;
      r_primed_p1 <= (w_state_nxt == S_RUN);
    end
  end

  assign oData   = r_data_p1;
  assign oValid  = r_vld_p1;
  assign oPrimed = r_primed_p1;

endmodule
